// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS-32 front end.
package mips_pkg;
  localparam int DEF_PC_WIDTH    = 32;
  localparam int DEF_INSTR_WIDTH = 32;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam int          PC_INC       = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef logic [DEF_PC_WIDTH-1:0]    pc_t;
  typedef logic [DEF_INSTR_WIDTH-1:0] instr_t;
endpackage

// File: rtl/if_stage_pipe_pc_reg.sv
// Program counter: branch redirect beats sequential increment, which beats hold.
// Also keeps the sticky flag for word-misaligned branch targets.
module pc_reg
  import mips_pkg::*;
#(
  parameter int                    PC_WIDTH = DEF_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = PC_WIDTH'(DEF_RESET_PC)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pc_write,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] pc,
  output logic                misalign_err
);

  logic [PC_WIDTH-1:0] r_pc;
  logic                r_misalign;
  logic [PC_WIDTH-1:0] w_pc_next;

  always_comb begin
    w_pc_next = r_pc;
    if (branch_taken)
      w_pc_next = {branch_target[PC_WIDTH-1:2], 2'b00};
    else if (pc_write)
      w_pc_next = r_pc + PC_WIDTH'(PC_INC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (branch_taken && (branch_target[1:0] != 2'b00))
        r_misalign <= 1'b1;
    end
  end

  assign pc           = r_pc;
  assign misalign_err = r_misalign;

endmodule

// File: rtl/if_stage_pipe.sv
// Instruction fetch stage with IF/ID pipeline register.
// Optional stall-cycle counter built only when IF_STALL_CNT_EN is defined.
module if_stage_pipe
  import mips_pkg::*;
#(
  parameter int                  PC_WIDTH    = DEF_PC_WIDTH,
  parameter int                  INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(DEF_RESET_PC),
  parameter int                  CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pc_write,
  input  logic                   if_id_write,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0]    if_id_pc_plus4,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic                   if_id_valid,
  output logic                   misalign_err,
  output logic [CNT_WIDTH-1:0]   stall_count
);

  logic [PC_WIDTH-1:0]    w_pc;
  logic [PC_WIDTH-1:0]    w_pc_plus4;
  logic [PC_WIDTH-1:0]    r_pc_plus4_p1;
  logic [INSTR_WIDTH-1:0] r_instr_p1;
  logic                   r_vld_p1;

  pc_reg #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_write      (pc_write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (w_pc),
    .misalign_err  (misalign_err)
  );

  assign imem_addr  = w_pc;
  assign w_pc_plus4 = w_pc + PC_WIDTH'(PC_INC);

  // IF -> ID boundary: a taken branch squashes the wrong-path fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_p1    <= INSTR_WIDTH'(NOP_INSTR);
      r_pc_plus4_p1 <= '0;
      r_vld_p1      <= 1'b0;
    end else if (branch_taken) begin
      r_instr_p1    <= INSTR_WIDTH'(NOP_INSTR);
      r_pc_plus4_p1 <= '0;
      r_vld_p1      <= 1'b0;
    end else if (if_id_write) begin
      r_instr_p1    <= imem_rdata;
      r_pc_plus4_p1 <= w_pc_plus4;
      r_vld_p1      <= 1'b1;
    end
  end

  assign if_id_instr    = r_instr_p1;
  assign if_id_pc_plus4 = r_pc_plus4_p1;
  assign if_id_valid    = r_vld_p1;

`ifdef IF_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  // A redirect is not a stall even when pc_write is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (!pc_write && !branch_taken && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
  end

  assign stall_count = r_stall_cnt;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_if_stage_pipe.sv
// Directed self-checking bench for if_stage_pipe; instruction memory returns addr ^ 32'hA5A5_0000.
module tb_if_stage_pipe;

  logic        clk;
  logic        rst_n;
  logic        pc_write;
  logic        if_id_write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        misalign_err;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  if_stage_pipe dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_instr    (if_id_instr),
    .if_id_valid    (if_id_valid),
    .misalign_err   (misalign_err),
    .stall_count    (stall_count)
  );

  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc_write = 1'b1; if_id_write = 1'b1;
    branch_taken = 1'b0; branch_target = 32'h0;
    step(); step();
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, 32'h0); end
    n_checks++; if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got=%h exp=%h", if_id_instr, 32'h0); end
    n_checks++; if (if_id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL rst_pc4 got=%h exp=%h", if_id_pc_plus4, 32'h0); end
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", if_id_valid); end
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL rst_misalign got=%b exp=0", misalign_err); end
    n_checks++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL rst_stallcnt got=%0d exp=0", stall_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    step();
    n_checks++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL fetch_addr1 got=%h exp=%h", imem_addr, 32'h4); end
    n_checks++; if (if_id_instr !== 32'hA5A5_0000) begin n_fail++; $display("FAIL fetch_instr1 got=%h exp=%h", if_id_instr, 32'hA5A5_0000); end
    n_checks++; if (if_id_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL fetch_pc4_1 got=%h exp=%h", if_id_pc_plus4, 32'h4); end
    n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid got=%b exp=1", if_id_valid); end
    step();
    n_checks++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL fetch_addr2 got=%h exp=%h", imem_addr, 32'h8); end
    n_checks++; if (if_id_instr !== 32'hA5A5_0004) begin n_fail++; $display("FAIL fetch_instr2 got=%h exp=%h", if_id_instr, 32'hA5A5_0004); end
    n_checks++; if (if_id_pc_plus4 !== 32'h8) begin n_fail++; $display("FAIL fetch_pc4_2 got=%h exp=%h", if_id_pc_plus4, 32'h8); end
  endtask

  task automatic test_stall();
    pc_write = 1'b0; if_id_write = 1'b0;
    step();
    n_checks++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL stall_addr got=%h exp=%h", imem_addr, 32'h8); end
    n_checks++; if (if_id_instr !== 32'hA5A5_0004) begin n_fail++; $display("FAIL stall_instr got=%h exp=%h", if_id_instr, 32'hA5A5_0004); end
    n_checks++; if (if_id_pc_plus4 !== 32'h8) begin n_fail++; $display("FAIL stall_pc4 got=%h exp=%h", if_id_pc_plus4, 32'h8); end
    pc_write = 1'b1; if_id_write = 1'b1;
    step();
    n_checks++; if (imem_addr !== 32'hC) begin n_fail++; $display("FAIL unstall_addr got=%h exp=%h", imem_addr, 32'hC); end
    n_checks++; if (if_id_instr !== 32'hA5A5_0008) begin n_fail++; $display("FAIL unstall_instr got=%h exp=%h", if_id_instr, 32'hA5A5_0008); end
    n_checks++; if (if_id_pc_plus4 !== 32'hC) begin n_fail++; $display("FAIL unstall_pc4 got=%h exp=%h", if_id_pc_plus4, 32'hC); end
  endtask

  task automatic test_branch_in_stall();
    pc_write = 1'b0; if_id_write = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h0000_0040;
    step();
    branch_taken = 1'b0; pc_write = 1'b1; if_id_write = 1'b1;
    n_checks++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL br_addr got=%h exp=%h", imem_addr, 32'h40); end
    n_checks++; if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL br_instr got=%h exp=%h", if_id_instr, 32'h0); end
    n_checks++; if (if_id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL br_pc4 got=%h exp=%h", if_id_pc_plus4, 32'h0); end
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL br_valid got=%b exp=0", if_id_valid); end
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL br_misalign got=%b exp=0", misalign_err); end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pre got=%h exp=%h", imem_addr, 32'hFFFF_FFFC); end
    step();
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr got=%h exp=%h", imem_addr, 32'h0); end
    n_checks++; if (if_id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4 got=%h exp=%h", if_id_pc_plus4, 32'h0); end
    n_checks++; if (if_id_instr !== 32'h5A5A_FFFC) begin n_fail++; $display("FAIL wrap_instr got=%h exp=%h", if_id_instr, 32'h5A5A_FFFC); end
    n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid got=%b exp=1", if_id_valid); end
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL wrap_misalign got=%b exp=0", misalign_err); end
  endtask

  task automatic test_misalign();
    branch_taken = 1'b1; branch_target = 32'h0000_0042;
    step();
    branch_taken = 1'b0;
    n_checks++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL mis_addr got=%h exp=%h", imem_addr, 32'h40); end
    n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_flag got=%b exp=1", misalign_err); end
    step(); step();
    n_checks++; if (imem_addr !== 32'h48) begin n_fail++; $display("FAIL mis_fetch_addr got=%h exp=%h", imem_addr, 32'h48); end
    n_checks++; if (if_id_instr !== 32'hA5A5_0044) begin n_fail++; $display("FAIL mis_fetch_instr got=%h exp=%h", if_id_instr, 32'hA5A5_0044); end
    n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_sticky got=%b exp=1", misalign_err); end
  endtask

  task automatic test_mixed();
    pc_write = 1'b0; if_id_write = 1'b1;
    step();
    n_checks++; if (imem_addr !== 32'h48) begin n_fail++; $display("FAIL mix1_addr got=%h exp=%h", imem_addr, 32'h48); end
    n_checks++; if (if_id_instr !== 32'hA5A5_0048) begin n_fail++; $display("FAIL mix1_instr got=%h exp=%h", if_id_instr, 32'hA5A5_0048); end
    n_checks++; if (if_id_pc_plus4 !== 32'h4C) begin n_fail++; $display("FAIL mix1_pc4 got=%h exp=%h", if_id_pc_plus4, 32'h4C); end
    pc_write = 1'b1; if_id_write = 1'b0;
    step();
    n_checks++; if (imem_addr !== 32'h4C) begin n_fail++; $display("FAIL mix2_addr got=%h exp=%h", imem_addr, 32'h4C); end
    n_checks++; if (if_id_instr !== 32'hA5A5_0048) begin n_fail++; $display("FAIL mix2_instr got=%h exp=%h", if_id_instr, 32'hA5A5_0048); end
    if_id_write = 1'b1;
  endtask

  task automatic test_back_to_back();
    branch_taken = 1'b1; branch_target = 32'h0000_0100;
    step();
    n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL b2b1_addr got=%h exp=%h", imem_addr, 32'h100); end
    branch_target = 32'h0000_0200;
    step();
    branch_taken = 1'b0;
    n_checks++; if (imem_addr !== 32'h200) begin n_fail++; $display("FAIL b2b2_addr got=%h exp=%h", imem_addr, 32'h200); end
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL b2b2_valid got=%b exp=0", if_id_valid); end
    step();
    n_checks++; if (imem_addr !== 32'h204) begin n_fail++; $display("FAIL b2b3_addr got=%h exp=%h", imem_addr, 32'h204); end
    n_checks++; if (if_id_instr !== 32'hA5A5_0200) begin n_fail++; $display("FAIL b2b3_instr got=%h exp=%h", if_id_instr, 32'hA5A5_0200); end
    n_checks++; if (if_id_pc_plus4 !== 32'h204) begin n_fail++; $display("FAIL b2b3_pc4 got=%h exp=%h", if_id_pc_plus4, 32'h204); end
  endtask

  task automatic test_stall_count_async_reset();
    logic [15:0] exp_cnt;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    pc_write = 1'b1; if_id_write = 1'b1;
    step(); step();
    pc_write = 1'b0; if_id_write = 1'b0;
    for (int i = 0; i < 5; i++) step();
`ifdef IF_STALL_CNT_EN
    exp_cnt = 16'd5;
`else
    exp_cnt = 16'd0;
`endif
    n_checks++; if (stall_count !== exp_cnt) begin n_fail++; $display("FAIL stallcnt got=%0d exp=%0d", stall_count, exp_cnt); end
    n_checks++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL stall5_addr got=%h exp=%h", imem_addr, 32'h8); end
    #3; rst_n = 1'b0; #1;
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL arst_addr got=%h exp=%h", imem_addr, 32'h0); end
    n_checks++; if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL arst_instr got=%h exp=%h", if_id_instr, 32'h0); end
    n_checks++; if (if_id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL arst_pc4 got=%h exp=%h", if_id_pc_plus4, 32'h0); end
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got=%b exp=0", if_id_valid); end
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL arst_misalign got=%b exp=0", misalign_err); end
    n_checks++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL arst_stallcnt got=%0d exp=0", stall_count); end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_branch_in_stall();
    test_wrap();
    test_misalign();
    test_mixed();
    test_back_to_back();
    test_stall_count_async_reset();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/if_stage_pipe.md
Name: if_stage_pipe

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS-32 core.
- Holds the PC and drives the instruction-memory address.
- Latches {PC+4, instruction} into IF/ID.
- Obeys the load-use stall controls (pc_write, if_id_write) from the hazard detection unit.
- Obeys branch redirect/flush from the ID stage.
- Sits directly upstream of the hazard detection unit: its if_id_instr[25:21]/[20:16] feed that unit's Rs/Rt compare.

Parameters:
PC_WIDTH, 32, width of PC and branch target
INSTR_WIDTH, 32, instruction word width
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_WIDTH, 16, stall-counter width (used only with IF_STALL_CNT_EN)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
pc_write  input  1  1 = PC may update; 0 = hold PC (load-use stall)
if_id_write  input  1  1 = IF/ID may load; 0 = hold IF/ID
branch_taken  input  1  branch/jump resolved taken in ID this cycle
branch_target  input  PC_WIDTH  redirect address, valid with branch_taken
imem_addr  output  PC_WIDTH  instruction-memory address (= current PC)
imem_rdata  input  INSTR_WIDTH  instruction word, combinational read of imem_addr
if_id_pc_plus4  output  PC_WIDTH  registered PC+4 of the fetched instruction
if_id_instr  output  INSTR_WIDTH  registered instruction
if_id_valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble
misalign_err  output  1  sticky flag: a branch_target with [1:0] != 0 was seen
stall_count  output  CNT_WIDTH  stall-cycle counter (only with IF_STALL_CNT_EN)

Behaviour:
- Reset (async, rst_n=0), all outputs take their reset values immediately:
  - pc = RESET_PC, so imem_addr = RESET_PC
  - if_id_pc_plus4 = 0, if_id_instr = 0 (NOP, sll $0,$0,0), if_id_valid = 0
  - misalign_err = 0, stall_count = 0
- Deassertion of rst_n is used as-is, no internal synchronizer; first fetch on the first rising edge after deassertion.
- imem_addr = pc, combinational from the PC register. Fetch latency is 1 cycle: the instruction at PC appears on if_id_instr the edge after PC is presented.
- PC update per edge, in priority order:
  1. branch_taken = 1: pc <= {branch_target[PC_WIDTH-1:2], 2'b00}. Overrides pc_write = 0.
  2. pc_write = 1: pc <= pc + 4, modulo 2^PC_WIDTH. 32'hFFFF_FFFC wraps to 0, no flag.
  3. Otherwise pc holds.
- IF/ID update per edge, in priority order:
  1. branch_taken = 1 (flush): if_id_instr <= 0, if_id_pc_plus4 <= 0, if_id_valid <= 0. Flush overrides if_id_write = 0.
  2. if_id_write = 1: if_id_instr <= imem_rdata, if_id_pc_plus4 <= pc + 4, if_id_valid <= 1.
  3. Otherwise all three hold.
- Stall rules:
  - pc_write = 0 with if_id_write = 0 is the normal load-use stall. No state changes, and the same imem_addr is re-presented.
  - Mixed values (pc_write != if_id_write) are legal and each register obeys its own enable. A bench must not flag them as errors.
- misalign_err: set when branch_taken = 1 and branch_target[1:0] != 2'b00. Stays set until reset. The redirect still happens to the aligned address.
- Back-to-back branch_taken on consecutive cycles: each edge redirects and flushes; the last target wins.
- No combinational path from any input to any output except imem_addr, which depends only on the PC register.

Optional Feature:
IF_STALL_CNT_EN
- Defined: stall_count increments on every edge with pc_write = 0 and branch_taken = 0. It saturates at all-ones, does not wrap, and resets to 0.
- Undefined: the stall_count port is present and tied to 0, and no counter logic is built.

Decomposition:
- Shared package mips_pkg holds:
  - NOP_INSTR = 32'h0000_0000
  - PC_INC = 4
  - RESET_PC default
  - typedefs for pc_t (PC_WIDTH bits) and instr_t (INSTR_WIDTH bits)
- One natural sub-module: pc_reg. It contains the PC register, the redirect/increment mux and the misalign flag. The IF/ID latch and the stall counter stay in the top module.

Test Plan:
- Reset release, pc_write = if_id_write = 1, imem returns addr^32'hA5A5_0000:
  - imem_addr = 0, 4, 8 on successive cycles
  - if_id_instr = 32'hA5A5_0000 one edge after imem_addr = 0
  - if_id_pc_plus4 = 4, if_id_valid = 1
- Load-use stall: pc_write = if_id_write = 0 for 1 cycle at PC = 8 → imem_addr stays 8 and IF/ID unchanged; PC advances to 12 once the stall releases.
- branch_taken = 1, target = 32'h0000_0040, during a stall → pc = 32'h40 next edge, if_id_instr = 0, if_id_valid = 0.
- branch_target = 32'h0000_0042 → pc = 32'h40, misalign_err = 1 and stays set across later normal fetches until rst_n = 0.
- PC = 32'hFFFF_FFFC, pc_write = 1 → next pc = 0, if_id_pc_plus4 = 0, no error.
- IF_STALL_CNT_EN defined:
  - 5 stall cycles → stall_count = 5
  - rst_n pulsed low mid-stall → all outputs return to reset values asynchronously, before the next clock edge
